// File: rtl/alpha_trim_mean_pkg.sv
// Shared definitions for the alpha-trimmed mean consumer: one-hot FSM codes and width helpers.
// Pure declarations, no logic of its own.
package alpha_trim_pkg;

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_GATHER = 5'b00010;
    localparam logic [4:0] S_ROUND  = 5'b00100;
    localparam logic [4:0] S_DIVIDE = 5'b01000;
    localparam logic [4:0] S_OUT    = 5'b10000;

    // Number of samples that survive trimming, i.e. the divisor.
    function automatic int trim_k(input int dn, input int trim);
        return dn - 2 * trim;
    endfunction

    // Accumulator width: enough to hold DN full-scale samples plus rounding.
    function automatic int sum_width(input int dn, input int dw);
        return dw + $clog2(dn);
    endfunction

endpackage

// File: rtl/alpha_trim_mean_if.sv
// Window/result bundle between the rank sorter and the trimmed-mean consumer.
// master drives the window and start pulse; slave returns the mean and status.
interface alpha_trim_mean_if #(
    parameter int DN = 25,
    parameter int DW = 8
);
    localparam int DW_sequence = $clog2(DN);

    logic                      start;
    logic [DN*DW-1:0]          data_unsort;
    logic [DN*DW_sequence-1:0] sequence_sorted;
    logic [DW-1:0]             mean_out;
    logic                      mean_valid;
    logic                      busy;
    logic                      idx_err;

    modport master (
        output start, data_unsort, sequence_sorted,
        input  mean_out, mean_valid, busy, idx_err
    );

    modport slave (
        input  start, data_unsort, sequence_sorted,
        output mean_out, mean_valid, busy, idx_err
    );
endinterface

// File: rtl/alpha_trim_mean_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses NW cycles after start is sampled.
// No backpressure: a new start simply restarts the division.
module seq_divider #(
    parameter int NW  = 13,
    parameter int DVW = 6,
    parameter int QW  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           div_start_i,
    input  logic [NW-1:0]  dividend_i,
    input  logic [DVW-1:0] divisor_i,
    output logic           div_done_o,
    output logic [QW-1:0]  quotient_o
);
    localparam int CW = $clog2(NW + 1);

    logic [NW-1:0]  quo_q;
    logic [DVW-1:0] rem_q;
    logic [DVW-1:0] dvs_q;
    logic [CW-1:0]  cnt_q;
    logic           done_q;

    logic [DVW:0]   shifted;
    logic           fits;
    logic [DVW-1:0] rem_d;

    // The remainder stays below the divisor, so the restored value always fits in DVW bits.
    always_comb begin
        shifted = {rem_q, quo_q[NW-1]};
        fits    = shifted >= {1'b0, dvs_q};
        rem_d   = fits ? DVW'(shifted - {1'b0, dvs_q}) : shifted[DVW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (div_start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
            cnt_q  <= CW'(NW);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            quo_q  <= {quo_q[NW-2:0], fits};
            rem_q  <= rem_d;
            cnt_q  <= cnt_q - 1'b1;
            done_q <= (cnt_q == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign div_done_o = done_q;
    assign quotient_o = quo_q[QW-1:0];

endmodule

// File: rtl/alpha_trim_mean.sv
// Captures a sorted window, sums the untrimmed ranks and divides with rounding; mean_valid DN+SW+2 cycles after start.
// No backpressure: start is honoured only in IDLE/OUT and ignored while busy.
module alpha_trim_mean
    import alpha_trim_pkg::*;
#(
    parameter int DN   = 25,
    parameter int DW   = 8,
    parameter int TRIM = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alpha_trim_mean_if.slave   bus
);
    localparam int DW_sequence = $clog2(DN);
    localparam int SW          = sum_width(DN, DW);
    localparam int K           = trim_k(DN, TRIM);

    logic [4:0]             state_q, state_d;
    logic [DW-1:0]          smp_q  [DN];
    logic [DW_sequence-1:0] slot_q [DN];
    logic [SW-1:0]          acc_q, acc_d;
    logic [DW_sequence-1:0] rank_q, rank_d;
    logic                   err_q, err_d;
    logic [DW-1:0]          mean_q, mean_d;

    logic                   accept;
    logic [DW_sequence-1:0] idx;
    logic                   idx_ok;
    logic                   keep;
    logic [DW-1:0]          sel;
    logic [SW-1:0]          rounded;
    logic                   div_start;
    logic                   div_done;
    logic [DW-1:0]          quot;

    always_comb begin
        idx    = slot_q[rank_q];
        idx_ok = {1'b0, idx} < (DW_sequence + 1)'(DN);
        keep   = (rank_q >= DW_sequence'(TRIM)) && (rank_q <= DW_sequence'(DN - 1 - TRIM));
        sel    = '0;
        for (int k = 0; k < DN; k++) begin
            if (idx == DW_sequence'(k)) sel = smp_q[k];
        end
        rounded = acc_q + SW'(K / 2);
        accept  = bus.start && ((state_q == S_IDLE) || (state_q == S_OUT));
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rank_d    = rank_q;
        err_d     = err_q;
        mean_d    = mean_q;
        div_start = 1'b0;
        case (state_q)
            S_GATHER: begin
                if (keep && idx_ok) acc_d = acc_q + SW'(sel);
                if (!idx_ok)        err_d = 1'b1;
                rank_d = rank_q + 1'b1;
                if (rank_q == DW_sequence'(DN - 1)) state_d = S_ROUND;
            end
            S_ROUND: begin
                div_start = 1'b1;
                state_d   = S_DIVIDE;
            end
            S_DIVIDE: begin
                if (div_done) begin
                    mean_d  = quot;
                    state_d = S_OUT;
                end
            end
            S_OUT:   state_d = S_IDLE;
            S_IDLE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A start in IDLE or OUT opens a fresh job with a clean accumulator and error flag.
        if (accept) begin
            state_d = S_GATHER;
            acc_d   = '0;
            rank_d  = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rank_q  <= '0;
            err_q   <= 1'b0;
            mean_q  <= '0;
            for (int k = 0; k < DN; k++) begin
                smp_q[k]  <= '0;
                slot_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rank_q  <= rank_d;
            err_q   <= err_d;
            mean_q  <= mean_d;
            if (accept) begin
                for (int k = 0; k < DN; k++) begin
                    smp_q[k]  <= bus.data_unsort[k*DW +: DW];
                    slot_q[k] <= bus.sequence_sorted[k*DW_sequence +: DW_sequence];
                end
            end
        end
    end

    seq_divider #(
        .NW  (SW),
        .DVW (DW_sequence + 1),
        .QW  (DW)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_start_i (div_start),
        .dividend_i  (rounded),
        .divisor_i   ((DW_sequence + 1)'(K)),
        .div_done_o  (div_done),
        .quotient_o  (quot)
    );

    assign bus.mean_out   = mean_q;
    assign bus.mean_valid = (state_q == S_OUT);
    assign bus.busy       = (state_q == S_GATHER) || (state_q == S_ROUND) || (state_q == S_DIVIDE);
    assign bus.idx_err    = err_q;

endmodule
